// File: rtl/grad_bram_sequencer.sv
// Gradient BRAM sequencer: fetches X/Y/Z/Z2 words per sample and issues them
// to the DAC interface once per programmable update interval.
module grad_bram_sequencer #(
    parameter int ADDR_W       = 13,
    parameter int INT_W        = 16,
    parameter int MIN_INTERVAL = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-3:0] last_sample_i,
    input  logic [INT_W-1:0]  interval_i,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic              bram_en_o,
    input  logic [31:0]       bram_data_i,
    output logic [23:0]       datax_o,
    output logic [23:0]       datay_o,
    output logic [23:0]       dataz_o,
    output logic [23:0]       dataz2_o,
    output logic              valid_o,
    input  logic              dac_busy_i,
    output logic              running_o,
    output logic              underrun_o,
    output logic              done_o,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] ISSUE = 2'd3;

    logic [1:0]        state;
    logic [2:0]        phase;
    logic [ADDR_W-3:0] k;
    logic [INT_W-1:0]  count;
    logic [INT_W-1:0]  reload;
    logic [23:0]       shadow_x, shadow_y, shadow_z, shadow_z2;
    logic              unused_hi;

    assign unused_hi = ^bram_data_i[31:24];
    assign fsm_state = state;

    // Counter value present in the issue cycle; it reaches 0 in the cycle the
    // next issue decision is taken, giving exactly one interval between pulses.
    assign reload = ((interval_i < INT_W'(MIN_INTERVAL)) ? INT_W'(MIN_INTERVAL) : interval_i)
                    - INT_W'(1);

    // Address phases 0..3; phase 4 only captures the Z2 word.
    assign bram_en_o   = (state == FETCH) && (phase < 3'd4);
    assign bram_addr_o = bram_en_o ? {k, phase[1:0]} : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            k          <= '0;
            count      <= '0;
            shadow_x   <= '0;
            shadow_y   <= '0;
            shadow_z   <= '0;
            shadow_z2  <= '0;
            datax_o    <= '0;
            datay_o    <= '0;
            dataz_o    <= '0;
            dataz2_o   <= '0;
            valid_o    <= 1'b0;
            running_o  <= 1'b0;
            underrun_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            if (count != '0) count <= count - INT_W'(1);

            if (state != IDLE && stop_i) begin
                state     <= IDLE;
                running_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && !stop_i) begin
                            state      <= FETCH;
                            phase      <= '0;
                            k          <= '0;
                            count      <= '0;
                            running_o  <= 1'b1;
                            underrun_o <= 1'b0;
                        end
                    end
                    FETCH: begin
                        case (phase)
                            3'd1:    shadow_x  <= bram_data_i[23:0];
                            3'd2:    shadow_y  <= bram_data_i[23:0];
                            3'd3:    shadow_z  <= bram_data_i[23:0];
                            3'd4:    shadow_z2 <= bram_data_i[23:0];
                            default: ;
                        endcase
                        if (phase == 3'd4) state <= HOLD;
                        else               phase <= phase + 3'd1;
                    end
                    HOLD: begin
                        if (count == '0) begin
                            if (dac_busy_i) begin
                                underrun_o <= 1'b1;
                            end else begin
                                state    <= ISSUE;
                                valid_o  <= 1'b1;
                                datax_o  <= shadow_x;
                                datay_o  <= shadow_y;
                                dataz_o  <= shadow_z;
                                dataz2_o <= shadow_z2;
                                count    <= reload;
                            end
                        end
                    end
                    ISSUE: begin
                        if (k == last_sample_i) begin
                            state     <= IDLE;
                            running_o <= 1'b0;
                            done_o    <= 1'b1;
                        end else begin
                            k     <= k + 1'b1;
                            phase <= '0;
                            state <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grad_bram_sequencer.sv
// Bench for grad_bram_sequencer: timestamp-based playback model checked every
// cycle, plus directed scenarios with hand-computed pulse times and data.
module tb_grad_bram_sequencer;

    localparam int ADDR_W = 13;
    localparam int INT_W  = 16;
    localparam int MIN_IV = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0, stop_i = 1'b0, dac_busy_i = 1'b0;
    logic [ADDR_W-3:0] last_sample_i = '0;
    logic [INT_W-1:0]  interval_i = 16'd100;
    logic [ADDR_W-1:0] bram_addr_o;
    logic              bram_en_o;
    logic [31:0]       bram_data_i = '0;
    logic [23:0]       datax_o, datay_o, dataz_o, dataz2_o;
    logic              valid_o, running_o, underrun_o, done_o;
    logic [1:0]        fsm_state;

    always #5 clk = ~clk;

    grad_bram_sequencer #(.ADDR_W(ADDR_W), .INT_W(INT_W), .MIN_INTERVAL(MIN_IV)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .last_sample_i(last_sample_i), .interval_i(interval_i),
        .bram_addr_o(bram_addr_o), .bram_en_o(bram_en_o), .bram_data_i(bram_data_i),
        .datax_o(datax_o), .datay_o(datay_o), .dataz_o(dataz_o), .dataz2_o(dataz2_o),
        .valid_o(valid_o), .dac_busy_i(dac_busy_i), .running_o(running_o),
        .underrun_o(underrun_o), .done_o(done_o), .fsm_state(fsm_state)
    );

    // BRAM: low 24 bits = word index + 1, upper byte is junk that must be ignored
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) if (bram_en_o) bram_data_i <= mem[bram_addr_o];

    // ---------------- counters and check tasks ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each sample k has a fetch start cycle m_f (addresses m_f..m_f+3, ready
    // from m_f+5) and an earliest decision cycle m_due; the pulse follows the
    // first cycle at or after both where the DAC is not busy.
    int cyc = 0;
    bit m_run = 0;
    int m_k = 0, m_f = 0, m_due = 0;
    bit e_valid = 0, e_done = 0, e_running = 0, e_underrun = 0;
    logic [23:0] e_data [4] = '{default: '0};

    always @(posedge clk) begin
        int c;
        bit nv, nd;
        c = cyc; nv = 0; nd = 0;
        if (!rst_n) begin
            m_run = 0; e_running = 0; e_underrun = 0;
            for (int i = 0; i < 4; i++) e_data[i] = '0;
        end else if (m_run && stop_i) begin
            m_run = 0; e_running = 0;
        end else if (!m_run) begin
            if (start_i && !stop_i) begin
                m_run = 1; e_running = 1; e_underrun = 0;
                m_k = 0; m_f = c + 1; m_due = c + 1;
            end
        end else if (e_valid) begin
            if (m_k == int'(last_sample_i)) begin
                m_run = 0; e_running = 0; nd = 1;
            end else begin
                m_k++; m_f = c + 1;
            end
        end else if (c >= m_f + 5 && c >= m_due) begin
            if (dac_busy_i) e_underrun = 1;
            else begin
                nv = 1;
                for (int i = 0; i < 4; i++) e_data[i] = mem[4*m_k + i][23:0];
                m_due = c + ((int'(interval_i) < MIN_IV) ? MIN_IV : int'(interval_i));
            end
        end
        e_valid = nv;
        e_done  = nd;
        cyc = c + 1;
    end

    // ---------------- scoreboard / compare ----------------
    int t0 = 0;
    int vq[$];
    int dq[$];
    logic [23:0] dxq[$];
    logic [23:0] dz2q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        bit e_en;
        if (cyc >= 1) begin
            e_en = m_run && cyc >= m_f && cyc < m_f + 4;
            chk("valid", 32'(valid_o), 32'(e_valid));
            chk("done", 32'(done_o), 32'(e_done));
            chk("running", 32'(running_o), 32'(e_running));
            chk("underrun", 32'(underrun_o), 32'(e_underrun));
            chk("bram_en", 32'(bram_en_o), 32'(e_en));
            chk("bram_addr", 32'(bram_addr_o), e_en ? 32'(4*m_k + cyc - m_f) : 32'd0);
            chk("datax", 32'(datax_o), 32'(e_data[0]));
            chk("datay", 32'(datay_o), 32'(e_data[1]));
            chk("dataz", 32'(dataz_o), 32'(e_data[2]));
            chk("dataz2", 32'(dataz2_o), 32'(e_data[3]));
            if (valid_o) begin
                vq.push_back(cyc - t0);
                dxq.push_back(datax_o);
                dz2q.push_back(dataz2_o);
            end
            if (done_o) dq.push_back(cyc - t0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic go_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic new_test(input int start_cyc);
        go_cycle(start_cyc);
        t0 = start_cyc;
        vq.delete(); dq.delete(); dxq.delete(); dz2q.delete();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        go_cycle(cyc + 1);
        start_i = 1'b0;
    endtask

    task automatic check_list(input string name, input int got[$]);
        chk($sformatf("%s count", name), 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", name, i), 32'(got[i]), exp_q[i]);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {8'(i*37 + 90), 24'(i + 1)};

        // reset
        go_cycle(2);
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset running", 32'(running_o), 32'd0);
        chk("reset datax", 32'(datax_o), 32'd0);
        rst_n = 1'b1;

        // single sample
        new_test(5);
        last_sample_i = '0; interval_i = 16'd100;
        pulse_start();
        go_cycle(t0 + 20);
        exp_q = '{32'd7}; check_list("single pulses", vq);
        exp_q = '{32'd8}; check_list("single done", dq);
        chk("single datax", 32'(dxq.size() > 0 ? dxq[0] : 24'hx), 32'd1);
        chk("single dataz2", 32'(dz2q.size() > 0 ? dz2q[0] : 24'hx), 32'd4);

        // periodic playback
        new_test(30);
        last_sample_i = 11'd3; interval_i = 16'd20;
        pulse_start();
        go_cycle(t0 + 80);
        exp_q = '{32'd7, 32'd27, 32'd47, 32'd67}; check_list("periodic pulses", vq);
        chk("periodic datax[3]", 32'(dxq.size() > 3 ? dxq[3] : 24'hx), 32'd13);
        chk("periodic underrun", 32'(underrun_o), 32'd0);

        // interval floor
        new_test(115);
        last_sample_i = 11'd2; interval_i = 16'd3;
        pulse_start();
        go_cycle(t0 + 35);
        exp_q = '{32'd7, 32'd15, 32'd23}; check_list("floor pulses", vq);
        exp_q = '{32'd24}; check_list("floor done", dq);

        // DAC stall
        new_test(155);
        last_sample_i = 11'd1; interval_i = 16'd20;
        pulse_start();
        go_cycle(t0 + 25); dac_busy_i = 1'b1;
        go_cycle(t0 + 31); dac_busy_i = 1'b0;
        go_cycle(t0 + 40);
        exp_q = '{32'd7, 32'd32}; check_list("stall pulses", vq);
        exp_q = '{32'd33}; check_list("stall done", dq);
        chk("stall datax[1]", 32'(dxq.size() > 1 ? dxq[1] : 24'hx), 32'd5);
        chk("stall underrun sticky", 32'(underrun_o), 32'd1);

        // abort during sample 2 of 4
        new_test(205);
        last_sample_i = 11'd3; interval_i = 16'd20;
        pulse_start();
        go_cycle(t0 + 26); dac_busy_i = 1'b1;
        go_cycle(t0 + 27); dac_busy_i = 1'b0;
        go_cycle(t0 + 30); stop_i = 1'b1;
        go_cycle(t0 + 31); stop_i = 1'b0;
        chk("abort running", 32'(running_o), 32'd0);
        go_cycle(t0 + 40);
        exp_q = '{32'd7, 32'd28}; check_list("abort pulses", vq);
        chk("abort done count", 32'(dq.size()), 32'd0);
        chk("abort underrun kept", 32'(underrun_o), 32'd1);

        // restart after abort
        new_test(250);
        last_sample_i = '0; interval_i = 16'd20;
        pulse_start();
        chk("restart underrun", 32'(underrun_o), 32'd0);
        chk("restart en", 32'(bram_en_o), 32'd1);
        chk("restart addr", 32'(bram_addr_o), 32'd0);
        go_cycle(t0 + 20);
        exp_q = '{32'd7}; check_list("restart pulses", vq);

        // reset mid-run, with start asserted during reset
        new_test(275);
        last_sample_i = 11'd3; interval_i = 16'd20;
        pulse_start();
        go_cycle(t0 + 40); rst_n = 1'b0; start_i = 1'b1;
        go_cycle(t0 + 41); rst_n = 1'b1; start_i = 1'b0;
        chk("midreset running", 32'(running_o), 32'd0);
        chk("midreset datax", 32'(datax_o), 32'd0);
        chk("midreset en", 32'(bram_en_o), 32'd0);
        go_cycle(t0 + 43);
        chk("midreset start ignored", 32'(running_o), 32'd0);
        new_test(320);
        last_sample_i = 11'd1;
        pulse_start();
        go_cycle(t0 + 40);
        exp_q = '{32'd7, 32'd27}; check_list("postreset pulses", vq);
        exp_q = '{32'd28}; check_list("postreset done", dq);

        // full address range at the floor interval
        new_test(365);
        last_sample_i = 11'd2047; interval_i = 16'd3;
        pulse_start();
        go_cycle(t0 + 16400);
        chk("max pulse count", 32'(vq.size()), 32'd2048);
        chk("max last pulse", 32'(vq.size() > 0 ? vq[$] : -1), 32'd16383);
        chk("max last datax", 32'(dxq.size() > 0 ? dxq[$] : 24'hx), 32'd8189);
        chk("max last dataz2", 32'(dz2q.size() > 0 ? dz2q[$] : 24'hx), 32'd8192);
        exp_q = '{32'd16384}; check_list("max done", dq);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grad_bram_sequencer.md
Name: grad_bram_sequencer

Overview:
- Upstream stage of the GPA-FHDO SPI interface.
- Fetches gradient samples from the gradient BRAM (four consecutive 32-bit words per sample: X, Y, Z, Z2) and assembles them into four 24-bit channel words.
- Presents one sample per programmable update interval as a single-cycle valid pulse, honouring the DAC interface's busy flag.
- Flags underruns when a sample cannot be issued on time.

Parameters:
- ADDR_W, 13, BRAM word-address width.
- INT_W, 16, width of the update-interval register.
- MIN_INTERVAL, 8, floor applied to interval_i, in clk cycles.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  one-cycle pulse; begins playback from sample 0
- stop_i  in  1  one-cycle pulse; aborts playback
- last_sample_i  in  ADDR_W-2  index of final sample; samples 0..last_sample_i are played
- interval_i  in  INT_W  clk cycles between successive valid_o pulses
- bram_addr_o  out  ADDR_W  BRAM word address
- bram_en_o  out  1  BRAM read enable
- bram_data_i  in  32  BRAM read data; 1-cycle read latency; bits [23:0] used
- datax_o, datay_o, dataz_o, dataz2_o  out  24 each  sample words to the DAC interface
- valid_o  out  1  one-cycle issue strobe
- dac_busy_i  in  1  DAC interface busy; no issue while high
- running_o  out  1  high from the cycle after an accepted start until return to IDLE
- underrun_o  out  1  sticky late-issue flag; cleared only by start_i or reset
- done_o  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs go to 0 on that edge; state IDLE; counters 0; any transfer in progress is abandoned.
- States: IDLE, FETCH, HOLD, ISSUE.
- IDLE:
  - start_i seen at cycle 0 → FETCH at cycle 1, sample index 0.
  - On an accepted start: running_o is set and underrun_o is cleared.
  - start_i in any other state is ignored.
- FETCH:
  - Drives bram_en_o=1 with addresses 4k, 4k+1, 4k+2, 4k+3 on four consecutive cycles.
  - Captures bram_data_i[23:0] one cycle after each address into X, Y, Z and Z2 shadow registers respectively.
  - Moves to HOLD in the cycle after the last capture.
  - bram_en_o is 0 outside these four address cycles.
- Interval counter:
  - Loaded with max(interval_i, MIN_INTERVAL) − 1 in each valid_o cycle.
  - Decrements each cycle, saturating at 0.
  - Is 0 at the start of playback.
- HOLD → ISSUE when fetch is complete, counter = 0 and dac_busy_i = 0.
- ISSUE (1 cycle):
  - Shadow registers are copied to data*_o, and valid_o=1 in that same cycle.
  - data*_o hold their value until the next issue.
  - If k = last_sample_i: go to IDLE with done_o=1 and running_o=0 on the next cycle.
  - Otherwise: k+1, FETCH next cycle. Prefetch overlaps the interval wait.
- Timing:
  - First issue: start at cycle 0, addresses on cycles 1–4, captures on cycles 2–5, HOLD on cycle 6, valid_o on cycle 7.
  - Unstalled steady state: valid_o exactly every max(interval_i, MIN_INTERVAL) cycles. Fetch takes 6 cycles, below the floor, so it never stalls.
- Underrun:
  - If the counter is 0 but the sample cannot be issued because dac_busy_i = 1, underrun_o is set (sticky).
  - Issue then occurs in the first cycle the condition clears; there is no skip and no drop.
- stop_i in any non-IDLE state:
  - IDLE next cycle, running_o=0, no further valid_o.
  - done_o stays 0.
  - data*_o keep their last values; underrun_o is kept.
- start_i and stop_i in the same cycle: stop_i wins; remain or return to IDLE.
- Address arithmetic:
  - bram_addr_o = {k, 2'b00} + word offset, ADDR_W bits.
  - last_sample_i at its maximum value (2^(ADDR_W−2) − 1) must work, with no wrap before completion.
- interval_i and last_sample_i:
  - interval_i is sampled at each counter load, so changes apply from the next sample.
  - last_sample_i is compared live.

Test Plan:
- Single sample: last_sample_i=0, BRAM[0..3]=0x000001, 0x000002, 0x000003, 0x000004, interval_i=100, start at cycle 0 → valid_o only at cycle 7 with data 1/2/3/4; done_o at cycle 8; running_o low at cycle 8.
- Periodic playback: last_sample_i=3, interval_i=20, dac_busy_i=0 → four valid_o pulses at cycles 7, 27, 47, 67 with the correct words; underrun_o=0.
- Interval floor: interval_i=3 → pulses spaced 8 cycles apart.
- DAC stall: hold dac_busy_i=1 over cycles 25–31 → second pulse at cycle 32 with the correct data; underrun_o=1 and it stays 1 after done_o.
- Abort: stop_i at cycle 30 during sample 2 of 4 → no further valid_o, done_o never asserted, running_o=0 at cycle 31; a new start_i clears underrun_o and replays from address 0.
- Reset mid-run: rst_n=0 for 1 cycle at cycle 40 → all outputs 0 on the next edge; start_i ignored while in reset; normal playback after release.
